// File: rtl/column_scan_sequencer.sv
// Column-pair scan sequencer: walks the column indices of one angular slice, fetching each pair
// from a combinational generator and presenting it to the panel driver over valid/ready.
module column_scan_sequencer #(
    parameter int unsigned ROTATIONAL_RES = 256,
    parameter int unsigned SCAN_RATE      = 32,
    parameter int unsigned NUM_ROWS       = 64,
    parameter int unsigned RGB_RES        = 9,
    localparam int unsigned AW = $clog2(ROTATIONAL_RES),
    localparam int unsigned CW = $clog2(SCAN_RATE),
    localparam int unsigned PW = 2 * NUM_ROWS * RGB_RES
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          tick_in,
    input  logic [AW-1:0] dtheta_in,
    output logic [AW-1:0] dtheta_out,
    output logic [CW-1:0] column_index1_out,
    output logic [CW:0]   column_index2_out,
    input  logic [PW-1:0] columns_in,
    output logic [PW-1:0] columns_out,
    output logic          valid_out,
    input  logic          ready_in,
    output logic          busy_out,
    output logic          slice_done_out,
    output logic [7:0]    overrun_count_out
);

    typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic          pending_q, pending_d;
    logic [AW-1:0] pend_dtheta_q, pend_dtheta_d;
    logic [AW-1:0] dtheta_q, dtheta_d;
    logic [PW-1:0] columns_q, columns_d;
    logic          slice_done_q, slice_done_d;
    logic [7:0]    overrun_q, overrun_d;

    logic tick_busy;
    logic handshake;
    logic last_col;

    assign tick_busy = tick_in && (state_q != StIdle);
    assign handshake = (state_q == StPresent) && ready_in;
    assign last_col  = (col_q == CW'(SCAN_RATE - 1));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        pending_d     = pending_q;
        pend_dtheta_d = pend_dtheta_q;
        dtheta_d      = dtheta_q;
        columns_d     = columns_q;
        slice_done_d  = 1'b0;
        overrun_d     = overrun_q;

        // A tick during a slice is queued; replacing an already-queued tick is an overrun.
        if (tick_busy) begin
            pending_d     = 1'b1;
            pend_dtheta_d = dtheta_in;
            if (pending_q && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (tick_in) begin
                    dtheta_d = dtheta_in;
                    col_d    = '0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                columns_d = columns_in;
                state_d   = StPresent;
            end
            StPresent: begin
                if (handshake && last_col) begin
                    slice_done_d = 1'b1;
                    col_d        = '0;
                    pending_d    = 1'b0;
                    // A tick arriving on the final handshake wins over the queued angle.
                    if (tick_in) begin
                        dtheta_d = dtheta_in;
                        state_d  = StFetch;
                    end else if (pending_q) begin
                        dtheta_d = pend_dtheta_q;
                        state_d  = StFetch;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (handshake) begin
                    col_d   = col_q + CW'(1);
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            col_q         <= '0;
            pending_q     <= 1'b0;
            pend_dtheta_q <= '0;
            dtheta_q      <= '0;
            columns_q     <= '0;
            slice_done_q  <= 1'b0;
            overrun_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            pending_q     <= pending_d;
            pend_dtheta_q <= pend_dtheta_d;
            dtheta_q      <= dtheta_d;
            columns_q     <= columns_d;
            slice_done_q  <= slice_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign dtheta_out        = dtheta_q;
    assign column_index1_out = col_q;
    assign column_index2_out = {1'b0, col_q} + (CW + 1)'(SCAN_RATE);
    assign columns_out       = columns_q;
    assign valid_out         = (state_q == StPresent);
    assign busy_out          = (state_q != StIdle);
    assign slice_done_out    = slice_done_q;
    assign overrun_count_out = overrun_q;

endmodule

// File: doc/column_scan_sequencer.md
COLUMN_SCAN_SEQUENCER -- requirements
Module: column_scan_sequencer

Interface
REQ-001 Parameter ROTATIONAL_RES, 256: discrete angular positions per revolution.
REQ-002 Parameter SCAN_RATE, 32: column pairs per angular slice.
REQ-003 Parameter NUM_ROWS, 64: pixels per column.
REQ-004 Parameter RGB_RES, 9: bits per pixel.
REQ-005 Port clk_in, input, 1: sole clock; every register updates on its rising edge.
REQ-006 Port rst_in, input, 1: synchronous, active-high reset.
REQ-007 Port tick_in, input, 1: one-cycle pulse; a new angular slice begins.
REQ-008 Port dtheta_in, input, clog2(ROTATIONAL_RES): slice angle; valid when tick_in=1.
REQ-009 Port dtheta_out, output, clog2(ROTATIONAL_RES): latched slice angle driven to the column generator.
REQ-010 Port column_index1_out, output, clog2(SCAN_RATE): left-half column index to the generator.
REQ-011 Port column_index2_out, output, clog2(SCAN_RATE)+1: right-half column index to the generator.
REQ-012 Port columns_in, input, 2 x NUM_ROWS x RGB_RES: combinational generator result for the current indices and angle.
REQ-013 Port columns_out, output, 2 x NUM_ROWS x RGB_RES: registered column pair presented to the panel driver.
REQ-014 Port valid_out, output, 1: columns_out holds a valid pair.
REQ-015 Port ready_in, input, 1: panel driver accepts the pair when valid_out and ready_in are both 1.
REQ-016 Port busy_out, output, 1: the sequencer is not in IDLE.
REQ-017 Port slice_done_out, output, 1: one-cycle pulse when the last pair of a slice is accepted.
REQ-018 Port overrun_count_out, output, 8: saturating count of ticks lost to replacement.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, FETCH and PRESENT.
REQ-020 In IDLE with tick_in=1, the block SHALL latch dtheta_in into dtheta_out, clear col to 0 and enter FETCH.
REQ-021 column_index1_out SHALL equal col, and column_index2_out SHALL equal col+SCAN_RATE, zero-extended; the sum is never truncated.
REQ-022 FETCH SHALL last exactly one cycle: the block captures columns_in into columns_out and enters PRESENT.
REQ-023 In PRESENT, valid_out=1, and columns_out, the indices and dtheta_out SHALL hold stable until the handshake completes.
REQ-024 On a handshake with col<SCAN_RATE-1, col SHALL increment and the FSM SHALL enter FETCH; the next valid_out comes 2 cycles later.
REQ-025 On a handshake with col=SCAN_RATE-1, slice_done_out SHALL pulse in the following cycle, and the FSM SHALL go to FETCH if a tick is pending and to IDLE otherwise.
REQ-026 A tick_in in FETCH or PRESENT SHALL set pending and store dtheta_in in pend_dtheta, and SHALL NOT disturb the slice in progress.
REQ-027 A tick_in while pending=1 SHALL overwrite pend_dtheta with the newer angle and increment overrun_count_out, saturating at 255.
REQ-028 When the final handshake and tick_in coincide, the incoming tick SHALL be the one started: it overwrites any pending angle and counts an overrun if pending was 1.
REQ-029 On starting from pending, the block SHALL load dtheta_out from pend_dtheta (or dtheta_in per REQ-028), clear pending and set col to 0.
REQ-030 valid_out SHALL be 1 only in PRESENT, and busy_out SHALL be 1 exactly when the state is not IDLE.
REQ-031 Worst-case slice time SHALL be 2*SCAN_RATE cycles when ready_in is held at 1.

Reset
REQ-032 While rst_in=1, on each edge: state=IDLE, col=0, pending=0, pend_dtheta=0, dtheta_out=0, columns_out=0, valid_out=0, slice_done_out=0, overrun_count_out=0; indices therefore read 0 and SCAN_RATE.
REQ-033 Reset asserted mid-slice SHALL abandon the slice without a slice_done_out pulse; tick_in during reset SHALL be ignored.

Verification
REQ-034 Tick with dtheta_in=5 and ready_in=1: 32 valid pairs are presented, indices run (0,32)..(31,63), dtheta_out=5, slice_done_out pulses at cycle 65 after the tick, then the FSM returns to IDLE.
REQ-035 ready_in held at 0 for 10 cycles at pair 3: columns_out, indices and valid_out stay stable for those 10 cycles, and pair 4 appears 2 cycles after acceptance.
REQ-036 Ticks at angles 7, 8 and 9 mid-slice: overrun_count_out=2 and the next slice runs with dtheta_out=9.
REQ-037 Tick coincident with the final handshake while angle 20 is pending: the new slice uses dtheta_in, and overrun_count_out increments by 1.
REQ-038 rst_in asserted during pair 10: one cycle later all outputs equal their REQ-032 values, and no slice_done_out pulse appears.
REQ-039 300 overrun ticks: overrun_count_out saturates at 255.
